// File: rtl/uc_secuenciador.sv
// uc_secuenciador: single-cycle CPU control unit with I/O wait/timeout, HALT/resume and return-stack guard
module uc_secuenciador #(
  parameter int IO_TIMEOUT  = 16,
  parameter int STACK_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       z,
  input  logic       start,
  input  logic       io_ack,
  output logic       s_inc,
  output logic       we3,
  output logic       wez,
  output logic       pushsignal,
  output logic       popsignal,
  output logic       s_stack,
  output logic       we4,
  output logic [1:0] s_inm,
  output logic [2:0] op_alu,
  output logic       pc_hold,
  output logic       io_rd,
  output logic       io_wr,
  output logic       halted,
  output logic       io_timeout,
  output logic       stack_err
);
  localparam int CW = $clog2(IO_TIMEOUT);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  typedef enum logic [1:0] {RUN, IO_WAIT, HALT} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_depth;
  logic r_is_in, r_io_timeout, r_stack_err;
  logic w_inc, w_dec, w_set_to, w_set_se;
  assign halted     = (r_state == HALT);
  assign io_timeout = r_io_timeout;
  assign stack_err  = r_stack_err;
  always_comb begin
    w_next     = r_state;
    s_inc      = 1'b1;
    we3        = 1'b0;
    wez        = 1'b0;
    pushsignal = 1'b0;
    popsignal  = 1'b0;
    s_stack    = 1'b0;
    we4        = 1'b0;
    s_inm      = 2'b00;
    op_alu     = 3'b000;
    pc_hold    = 1'b0;
    io_rd      = 1'b0;
    io_wr      = 1'b0;
    w_inc      = 1'b0;
    w_dec      = 1'b0;
    w_set_to   = 1'b0;
    w_set_se   = 1'b0;
    if (!reset) begin
      pc_hold = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (opcode[5:3] == 3'b000) begin
            op_alu = opcode[2:0];
            we3    = 1'b1;
            wez    = 1'b1;
          end else begin
            case (opcode)
              6'b001000: begin we3 = 1'b1; s_inm = 2'b01; end
              6'b001001: begin we3 = 1'b1; s_inm = 2'b10; end
              6'b001010: we4 = 1'b1;
              6'b001011: begin io_rd = 1'b1; pc_hold = 1'b1; w_next = IO_WAIT; end
              6'b001100: begin io_wr = 1'b1; pc_hold = 1'b1; w_next = IO_WAIT; end
              6'b010000: s_inc = 1'b0;
              6'b010001: s_inc = ~z;
              6'b010010: s_inc = z;
              6'b010011: begin
                // the jump is taken even when the push is suppressed
                s_inc = 1'b0;
                if (r_depth == DW'(STACK_DEPTH)) w_set_se = 1'b1;
                else begin pushsignal = 1'b1; w_inc = 1'b1; end
              end
              6'b010100: begin
                if (r_depth == '0) w_set_se = 1'b1;
                else begin popsignal = 1'b1; s_stack = 1'b1; w_dec = 1'b1; end
              end
              6'b111111: begin pc_hold = 1'b1; w_next = HALT; end
              default: ;
            endcase
          end
        end
        IO_WAIT: begin
          io_rd   = r_is_in;
          io_wr   = ~r_is_in;
          pc_hold = 1'b1;
          // ack wins over a simultaneous timeout
          if (io_ack) begin
            pc_hold = 1'b0;
            we3     = r_is_in;
            s_inm   = r_is_in ? 2'b11 : 2'b00;
            w_next  = RUN;
          end else if (r_cnt == CW'(IO_TIMEOUT - 1)) begin
            pc_hold  = 1'b0;
            w_set_to = 1'b1;
            w_next   = RUN;
          end
        end
        HALT: begin
          pc_hold = 1'b1;
          w_next  = start ? RUN : HALT;
        end
        default: w_next = RUN;
      endcase
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_cnt        <= '0;
      r_depth      <= '0;
      r_is_in      <= 1'b0;
      r_io_timeout <= 1'b0;
      r_stack_err  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (r_state == IO_WAIT && w_next == IO_WAIT) ? r_cnt + 1'b1 : '0;
      r_depth      <= w_inc ? r_depth + 1'b1 : w_dec ? r_depth - 1'b1 : r_depth;
      r_is_in      <= (r_state == RUN) ? (opcode == 6'b001011) : r_is_in;
      r_io_timeout <= w_set_to | (r_io_timeout & ~start);
      r_stack_err  <= w_set_se | (r_stack_err & ~start);
    end
  end
endmodule

// File: tb/tb_uc_secuenciador.sv
// tb_uc_secuenciador: directed self-checking bench for uc_secuenciador
module tb_uc_secuenciador;
  logic clk = 1'b0, reset = 1'b0, z = 1'b0, start = 1'b0, io_ack = 1'b0;
  logic [5:0] opcode = 6'b000010;
  logic s_inc, we3, wez, pushsignal, popsignal, s_stack, we4, pc_hold, io_rd, io_wr, halted, io_timeout, stack_err;
  logic [1:0] s_inm;
  logic [2:0] op_alu;
  int checks = 0, failures = 0;
  localparam logic [5:0] NOP = 6'b100000, ALU1 = 6'b000001, IN = 6'b001011, OUT = 6'b001100;
  localparam logic [5:0] CALL = 6'b010011, RET = 6'b010100, HLT = 6'b111111;
  uc_secuenciador #(.IO_TIMEOUT(16), .STACK_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .start(start), .io_ack(io_ack),
    .s_inc(s_inc), .we3(we3), .wez(wez), .pushsignal(pushsignal), .popsignal(popsignal),
    .s_stack(s_stack), .we4(we4), .s_inm(s_inm), .op_alu(op_alu), .pc_hold(pc_hold),
    .io_rd(io_rd), .io_wr(io_wr), .halted(halted), .io_timeout(io_timeout), .stack_err(stack_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #2;
  endtask
  initial begin
    #1;
    chk("rst_pc_hold", pc_hold, 1);
    chk("rst_we3", we3, 0);
    chk("rst_wez", wez, 0);
    chk("rst_s_inc", s_inc, 1);
    chk("rst_op_alu", op_alu, 0);
    chk("rst_s_inm", s_inm, 0);
    cyc; cyc; cyc;
    chk("rst_hold_late", pc_hold, 1);
    chk("rst_we3_late", we3, 0);
    reset = 1'b1; #1;
    chk("alu_we3", we3, 1);
    chk("alu_wez", wez, 1);
    chk("alu_op", op_alu, 3'b010);
    chk("alu_pc_hold", pc_hold, 0);
    chk("flags_after_rst", {io_timeout, stack_err, halted}, 0);
    opcode = 6'b010001; z = 1'b1; #1; chk("jz_taken", s_inc, 0);
    z = 1'b0; #1; chk("jz_not", s_inc, 1);
    opcode = 6'b010010; #1; chk("jnz_taken", s_inc, 0);
    z = 1'b1; #1; chk("jnz_not", s_inc, 1);
    opcode = 6'b010000; #1; chk("j", s_inc, 0);
    opcode = 6'b001000; #1; chk("li", {we3, s_inm}, 3'b101);
    opcode = 6'b001001; #1; chk("ld", {we3, s_inm}, 3'b110);
    opcode = 6'b001010; #1; chk("st", {we4, we3, wez}, 3'b100);
    opcode = NOP; #1; chk("nop", {s_inc, we3, we4, pc_hold}, 4'b1000);
    opcode = CALL; #1; chk("call", {pushsignal, s_inc}, 2'b10);
    cyc; opcode = RET; #1; chk("ret", {popsignal, s_stack, s_inc}, 3'b111);
    cyc; #1; chk("ret_empty", {popsignal, s_stack, s_inc}, 3'b001);
    cyc; opcode = NOP; #1; chk("se_set", stack_err, 1);
    start = 1'b1; cyc; start = 1'b0; #1; chk("se_clr", stack_err, 0);
    opcode = IN; #1; chk("in_issue", {io_rd, pc_hold, we3}, 3'b110);
    for (int i = 0; i < 3; i++) begin
      cyc; #1; chk("in_wait", {io_rd, pc_hold, we3}, 3'b110);
    end
    cyc; io_ack = 1'b1; #1;
    chk("in_ack", {pc_hold, we3, s_inm}, 4'b0111);
    cyc; io_ack = 1'b0; opcode = NOP; #1;
    chk("in_done", {io_rd, pc_hold, halted, io_timeout}, 0);
    opcode = OUT; #1; chk("out_issue", {io_wr, pc_hold}, 2'b11);
    for (int i = 0; i < 15; i++) begin
      cyc; #1; chk("out_wait", {io_wr, pc_hold}, 2'b11);
    end
    cyc; #1; chk("out_abandon", {pc_hold, we3, we4, io_timeout}, 0);
    cyc; opcode = NOP; #1; chk("to_set", {io_timeout, io_wr}, 2'b10);
    cyc; #1; chk("to_sticky", io_timeout, 1);
    start = 1'b1; cyc; start = 1'b0; #1; chk("to_clr", io_timeout, 0);
    opcode = CALL;
    for (int i = 0; i < 16; i++) begin
      #1; chk("call_fill", pushsignal, 1); cyc;
    end
    #1; chk("call_full", {pushsignal, s_inc, stack_err}, 3'b000);
    cyc; opcode = NOP; #1; chk("full_err", stack_err, 1);
    start = 1'b1; cyc; start = 1'b0; opcode = RET;
    for (int i = 0; i < 16; i++) begin
      #1; chk("ret_drain", {popsignal, s_stack}, 2'b11); cyc;
    end
    #1; chk("ret_underflow", {popsignal, s_stack, s_inc}, 3'b001);
    cyc; opcode = HLT; #1; chk("halt_issue", {pc_hold, halted, stack_err}, 3'b101);
    cyc; opcode = ALU1;
    for (int i = 0; i < 10; i++) begin
      #1; chk("halted", {halted, pc_hold, we3, wez}, 4'b1100); cyc;
    end
    #1; chk("halt_err_kept", stack_err, 1);
    start = 1'b1; cyc; start = 1'b0; #1;
    chk("resume", {halted, pc_hold, we3, stack_err}, 4'b0010);
    opcode = HLT; cyc; opcode = ALU1; #1; chk("halt2", halted, 1);
    reset = 1'b0; #1; chk("rst_in_halt", {halted, pc_hold, we3}, 3'b010);
    cyc; reset = 1'b1; #1; chk("after_rst", {halted, pc_hold, we3, op_alu}, 6'b001001);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
